// File: rtl/led_scan_sequencer.sv
// LED scan sequencer: steps one lit LED across 8 positions for a 3-to-8 decoder.
// Optional macro LED_SCAN_BLANK_EN inserts one blank cycle before each lit step.
module led_scan_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       switch,
  output logic [2:0]       enable,
  output logic [7:0]       led,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre_q;
  logic             dir_q;
  logic [2:0]       switch_q;
  logic [2:0]       enable_q;
  logic [7:0]       led_q;
  logic             busy_q;
  logic             wrap_q;
  logic             done_q;
`ifdef LED_SCAN_BLANK_EN
  logic             blank_q;
`endif

  logic [2:0] switch_d;
  logic       dir_d;
  logic       wrap_d;
  logic       last_d;
  logic [2:0] init_sw;

  function automatic logic [7:0] led_of(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

  assign init_sw = (mode == 2'b01) ? 3'd7 : 3'd0;

  // Next scan index, direction and wrap/end flags for the pending step.
  always_comb begin
    switch_d = switch_q + 3'd1;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    last_d   = 1'b0;
    case (mode_q)
      2'b00: wrap_d = (switch_q == 3'd7);
      2'b01: begin
        switch_d = switch_q - 3'd1;
        wrap_d   = (switch_q == 3'd0);
      end
      2'b10: begin
        if (!dir_q) begin
          if (switch_q == 3'd7) begin
            switch_d = 3'd6;
            dir_d    = 1'b1;
          end
        end else if (switch_q == 3'd0) begin
          switch_d = 3'd1;
          dir_d    = 1'b0;
          wrap_d   = 1'b1;
        end else begin
          switch_d = switch_q - 3'd1;
        end
      end
      default: last_d = (switch_q == 3'd7);
    endcase
  end

  // Scan FSM with all outputs registered on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      div_q    <= '0;
      pre_q    <= '0;
      dir_q    <= 1'b0;
      switch_q <= 3'd0;
      enable_q <= EN_OFF;
      led_q    <= 8'hff;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LED_SCAN_BLANK_EN
      blank_q  <= 1'b0;
`endif
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            mode_q   <= mode;
            div_q    <= div;
            pre_q    <= '0;
            dir_q    <= 1'b0;
            switch_q <= init_sw;
`ifdef LED_SCAN_BLANK_EN
            blank_q  <= 1'b1;
            enable_q <= EN_OFF;
            led_q    <= 8'hff;
`else
            enable_q <= EN_ON;
            led_q    <= led_of(init_sw);
`endif
          end
        end
        default: begin
          if (stop) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            enable_q <= EN_OFF;
            led_q    <= 8'hff;
`ifdef LED_SCAN_BLANK_EN
            blank_q  <= 1'b0;
`endif
          end else if (hold) begin
            state_q <= RUN;
`ifdef LED_SCAN_BLANK_EN
          end else if (blank_q) begin
            blank_q  <= 1'b0;
            enable_q <= EN_ON;
            led_q    <= led_of(switch_q);
`endif
          end else if (pre_q == div_q) begin
            pre_q <= '0;
            if (last_d) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              enable_q <= EN_OFF;
              led_q    <= 8'hff;
              wrap_q   <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              wrap_q   <= wrap_d;
              switch_q <= switch_d;
              dir_q    <= dir_d;
`ifdef LED_SCAN_BLANK_EN
              blank_q  <= 1'b1;
              enable_q <= EN_OFF;
              led_q    <= 8'hff;
`else
              led_q    <= led_of(switch_d);
`endif
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign switch = switch_q;
  assign enable = enable_q;
  assign led    = led_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
- Sequences the 3-to-8 active-low LED decoder path by generating its `switch` index and `enable` code.
- Steps one lit LED across the 8 positions in a programmed pattern, at a programmable rate.
- Also drives a registered copy of the decoded active-low LED vector, so it can be used standalone or alongside the decoder.
- Sits between control logic (start/stop/mode) and the LED decoder / board LEDs.

Parameters:
- DIV_W, 8, width of the step prescaler and the `div` input.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  level-sampled; begins a scan when in IDLE
- stop  input  1  level-sampled; aborts a scan, return to IDLE
- hold  input  1  freezes scan position and prescaler while in RUN
- mode  input  2  00 up loop, 01 down loop, 10 ping-pong loop, 11 single-shot up
- div  input  DIV_W  step period is div+1 clk cycles
- switch  output  3  decoder index, registered
- enable  output  3  decoder enable code, registered; 3'b100 = active, 3'b000 = blank
- led  output  8  registered active-low one-hot, ~(1<<switch) when enable==3'b100, else 8'hff
- busy  output  1  high while in RUN
- wrap  output  1  one-cycle pulse on pattern wrap or end
- done  output  1  one-cycle pulse when a single-shot scan completes

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, switch=3'd0, enable=3'b000, led=8'hff, busy=0, wrap=0, done=0, prescaler=0, direction=up.
- All outputs are registered and update on the same edge, so switch, enable and led are always mutually consistent.
- FSM has two states, IDLE and RUN.
- IDLE:
  - enable=000, led=ff.
  - If start=1 and stop=0 at a clock edge: go to RUN; latch mode and div; clear the prescaler; enable=100.
  - Initial switch is 7 for mode 01, otherwise 0. Direction is set to up.
  - So the first LED is lit on the edge after start is sampled.
- RUN:
  - Priority is stop > hold > step.
  - stop=1: go to IDLE next edge; enable=000, led=ff, switch keeps its value, no wrap/done pulse.
  - hold=1: prescaler, switch and direction frozen; LED stays lit.
  - Otherwise the prescaler increments. When prescaler == latched div, it clears to 0 and a step occurs. div=0 means a step every cycle.
  - start is ignored while in RUN. mode and div changes take effect only at the next start.
- Step rules:
  - Up (00): 0→1→…→7→0. wrap=1 on the 7→0 step.
  - Down (01): 7→6→…→0→7. wrap=1 on the 0→7 step.
  - Ping-pong (10): 0,1…7,6…1,0,1…; each endpoint is shown for exactly one step period. Direction flips when stepping off 7 and off 0. wrap=1 on the step that leaves 0 after a downward run (not on the first step from start).
  - Single-shot (11): as Up, but the step from 7 goes to IDLE instead. enable=000, led=ff, wrap=1 and done=1 are all on that edge; switch stays 7.
- wrap and done are high for exactly one cycle and are 0 in all other cycles.
- Reset asserted mid-scan forces the reset values immediately, with no clock required.
- Simultaneous start and stop in IDLE: stays in IDLE.
- busy is 1 exactly while state==RUN.

Optional Feature:
- Macro: LED_SCAN_BLANK_EN.
- When defined:
  - Each step is preceded by one blank cycle: enable=000, led=ff, switch already at the new index.
  - The lit portion lasts div+1 cycles, so the step period is div+2.
  - The first LED after start is also preceded by one blank cycle.
  - wrap and done pulse on the blank cycle's edge.
  - hold during a blank cycle freezes it blank.
- When not defined: no blank cycles; step period is div+1.

Test Plan:
- Up scan: reset, mode=00, div=0, start pulse → led cycles fe,fd,fb,f7,ef,df,bf,7f,fe…, one value per clk; wrap=1 coincident with the 7f→fe change.
- Down scan: mode=01, div=2 → switch 7,6,5… with each value held 3 cycles; wrap on the 0→7 step; busy=1 throughout.
- Ping-pong: mode=10, div=0 → switch 0..7,6..0,1; first wrap pulse appears when switch goes 0→1 after the descent, 15 steps after start.
- Single-shot: mode=11, div=1 → 8 indices × 2 cycles each, then enable=000, led=ff, done=1 and wrap=1 for one cycle, busy=0.
- Hold and stop:
  - hold=1 for 5 cycles mid-scan → led is unchanged, and the remaining prescaler count resumes afterwards.
  - stop together with a pending step → next edge IDLE, led=ff, no wrap.
  - Async rst pulse between clock edges → led=ff immediately.
- With LED_SCAN_BLANK_EN, mode=00, div=0 → led alternates ff,fe,ff,fd,ff,fb…; step period is 2 cycles.
